// File: rtl/cla_adder_pipe_pkg.sv
// Shared constants for the pipelined carry-lookahead add/subtract unit.
// Holds the operation encodings and the group-count helper used at elaboration.
package cla_adder_pipe_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   function automatic int n_groups(input int width, input int group);
      return width / group;
   endfunction

endpackage

// File: rtl/cla_adder_pipe_group.sv
// First-level carry-lookahead group: GROUP-bit sum plus group generate/propagate.
// Every internal carry is a flat sum-of-products of g/p terms rather than a ripple chain.
module cla_group #(
   parameter int GROUP = 4
) (
   input  logic [GROUP-1:0] a,
   input  logic [GROUP-1:0] b,
   input  logic             cin,
   output logic [GROUP-1:0] sum,
   output logic             group_g,
   output logic             group_p
);

   logic [GROUP-1:0] g_s;
   logic [GROUP-1:0] p_s;
   logic [GROUP:0]   c_s;
   logic             term_v;
   logic             acc_v;
   logic             gterm_v;
   logic             gacc_v;

   assign g_s = a & b;
   assign p_s = a ^ b;

   // Bit carries: c[i] = cin&P[i-1:0] | OR_j g[j]&P[i-1:j+1]
   always_comb begin
      c_s    = {(GROUP+1){1'b0}};
      term_v = 1'b0;
      acc_v  = 1'b0;
      c_s[0] = cin;
      for (int i = 1; i <= GROUP; i++) begin
         term_v = cin;
         for (int m = 0; m < i; m++) begin
            term_v = term_v & p_s[m];
         end
         acc_v = term_v;
         for (int j = 0; j < i; j++) begin
            term_v = g_s[j];
            for (int m = j + 1; m < i; m++) begin
               term_v = term_v & p_s[m];
            end
            acc_v = acc_v | term_v;
         end
         c_s[i] = acc_v;
      end
   end

   // Group generate/propagate feeding the second-level lookahead unit
   always_comb begin
      gterm_v = 1'b0;
      gacc_v  = 1'b0;
      for (int j = 0; j < GROUP; j++) begin
         gterm_v = g_s[j];
         for (int m = j + 1; m < GROUP; m++) begin
            gterm_v = gterm_v & p_s[m];
         end
         gacc_v = gacc_v | gterm_v;
      end
   end

   assign group_g = gacc_v;
   assign group_p = &p_s;
   assign sum     = p_s ^ c_s[GROUP-1:0];

endmodule

// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined carry-lookahead add/subtract with valid/ready on both sides.
// Stage 1 registers conditioned operands and group G/P; stage 2 registers sum and flags.
module cla_adder_pipe
   import cla_adder_pipe_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int GROUP = 4,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_op,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             out_zero,
   output logic [TAG_W-1:0] out_tag
);

   localparam int NG = n_groups(WIDTH, GROUP);

   if ((WIDTH % GROUP) != 0) begin : g_width_chk
      $error("cla_adder_pipe: WIDTH must be a multiple of GROUP");
   end
   if ((GROUP < 2) || (GROUP > 8)) begin : g_group_chk
      $error("cla_adder_pipe: GROUP must be in 2..8");
   end
   if (TAG_W < 1) begin : g_tag_chk
      $error("cla_adder_pipe: TAG_W must be at least 1");
   end

   logic [WIDTH-1:0] b_eff_s;
   logic             c0_s;
   logic [NG-1:0]    g1_s;
   logic [NG-1:0]    p1_s;
   logic [WIDTH-1:0] unused_s1_sum;
   logic [NG-1:0]    unused_s2_g;
   logic [NG-1:0]    unused_s2_p;

   logic             s1_valid_d, s1_valid_q;
   logic [WIDTH-1:0] s1_a_d, s1_a_q;
   logic [WIDTH-1:0] s1_b_d, s1_b_q;
   logic             s1_c0_d, s1_c0_q;
   logic [TAG_W-1:0] s1_tag_d, s1_tag_q;
   logic [NG-1:0]    s1_g_d, s1_g_q;
   logic [NG-1:0]    s1_p_d, s1_p_q;

   logic [NG:0]      carry_s;
   logic             la_term_v;
   logic             la_acc_v;
   logic [WIDTH-1:0] sum_s;
   logic             cout_s;
   logic             msb_cin_s;
   logic             ovf_s;
   logic             zero_s;

   logic             s2_valid_d, s2_valid_q;
   logic [WIDTH-1:0] sum_d, sum_q;
   logic             cout_d, cout_q;
   logic             ovf_d, ovf_q;
   logic             zero_d, zero_q;
   logic [TAG_W-1:0] tag_d, tag_q;

   logic             s2_adv_s;
   logic             s1_adv_s;

   // Subtraction is a + ~b + ~borrow, so invert b and the carry-in for SUB
   always_comb begin
      b_eff_s = in_b;
      c0_s    = in_cin;
      if (in_op == OP_SUB) begin
         b_eff_s = ~in_b;
         c0_s    = ~in_cin;
      end else begin
         b_eff_s = in_b;
         c0_s    = in_cin;
      end
   end

   for (genvar k = 0; k < NG; k++) begin : g_grp
      cla_group #(.GROUP(GROUP)) u_gp (
         .a       (in_a[k*GROUP +: GROUP]),
         .b       (b_eff_s[k*GROUP +: GROUP]),
         .cin     (1'b0),
         .sum     (unused_s1_sum[k*GROUP +: GROUP]),
         .group_g (g1_s[k]),
         .group_p (p1_s[k])
      );
      cla_group #(.GROUP(GROUP)) u_sum (
         .a       (s1_a_q[k*GROUP +: GROUP]),
         .b       (s1_b_q[k*GROUP +: GROUP]),
         .cin     (carry_s[k]),
         .sum     (sum_s[k*GROUP +: GROUP]),
         .group_g (unused_s2_g[k]),
         .group_p (unused_s2_p[k])
      );
   end

   assign s2_adv_s = ~s2_valid_q | out_ready;
   assign s1_adv_s = ~s1_valid_q | s2_adv_s;
   assign in_ready = s1_adv_s;

   // Stage 1 next state: load on input accept, drop valid when draining with no new op
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_c0_d    = s1_c0_q;
      s1_tag_d   = s1_tag_q;
      s1_g_d     = s1_g_q;
      s1_p_d     = s1_p_q;
      if (s1_adv_s) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_a_d   = in_a;
            s1_b_d   = b_eff_s;
            s1_c0_d  = c0_s;
            s1_tag_d = in_tag;
            s1_g_d   = g1_s;
            s1_p_d   = p1_s;
         end else begin
            s1_a_d   = s1_a_q;
            s1_tag_d = s1_tag_q;
         end
      end else begin
         s1_valid_d = s1_valid_q;
      end
   end

   // Second-level lookahead: each group carry is flat over registered G/P and c0
   always_comb begin
      carry_s    = {(NG+1){1'b0}};
      la_term_v  = 1'b0;
      la_acc_v   = 1'b0;
      carry_s[0] = s1_c0_q;
      for (int k = 1; k <= NG; k++) begin
         la_term_v = s1_c0_q;
         for (int m = 0; m < k; m++) begin
            la_term_v = la_term_v & s1_p_q[m];
         end
         la_acc_v = la_term_v;
         for (int j = 0; j < k; j++) begin
            la_term_v = s1_g_q[j];
            for (int m = j + 1; m < k; m++) begin
               la_term_v = la_term_v & s1_p_q[m];
            end
            la_acc_v = la_acc_v | la_term_v;
         end
         carry_s[k] = la_acc_v;
      end
   end

   assign cout_s    = carry_s[NG];
   assign msb_cin_s = sum_s[WIDTH-1] ^ s1_a_q[WIDTH-1] ^ s1_b_q[WIDTH-1];
   assign ovf_s     = msb_cin_s ^ cout_s;
   assign zero_s    = (sum_s == {WIDTH{1'b0}});

   // Stage 2 next state: results freeze under backpressure, valid clears after handoff
   always_comb begin
      s2_valid_d = s2_valid_q;
      sum_d      = sum_q;
      cout_d     = cout_q;
      ovf_d      = ovf_q;
      zero_d     = zero_q;
      tag_d      = tag_q;
      if (s2_adv_s) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            sum_d  = sum_s;
            cout_d = cout_s;
            ovf_d  = ovf_s;
            zero_d = zero_s;
            tag_d  = s1_tag_q;
         end else begin
            sum_d = sum_q;
            tag_d = tag_q;
         end
      end else begin
         s2_valid_d = s2_valid_q;
      end
   end

   // Pipeline registers with synchronous reset discarding in-flight ops
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_a_q     <= {WIDTH{1'b0}};
         s1_b_q     <= {WIDTH{1'b0}};
         s1_c0_q    <= 1'b0;
         s1_tag_q   <= {TAG_W{1'b0}};
         s1_g_q     <= {NG{1'b0}};
         s1_p_q     <= {NG{1'b0}};
         s2_valid_q <= 1'b0;
         sum_q      <= {WIDTH{1'b0}};
         cout_q     <= 1'b0;
         ovf_q      <= 1'b0;
         zero_q     <= 1'b0;
         tag_q      <= {TAG_W{1'b0}};
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s1_c0_q    <= s1_c0_d;
         s1_tag_q   <= s1_tag_d;
         s1_g_q     <= s1_g_d;
         s1_p_q     <= s1_p_d;
         s2_valid_q <= s2_valid_d;
         sum_q      <= sum_d;
         cout_q     <= cout_d;
         ovf_q      <= ovf_d;
         zero_q     <= zero_d;
         tag_q      <= tag_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign out_sum   = sum_q;
   assign out_cout  = cout_q;
   assign out_ovf   = ovf_q;
   assign out_zero  = zero_q;
   assign out_tag   = tag_q;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Bench for cla_adder_pipe: directed vector table, backpressure, random stream, mid-flight reset.
// Results are scored against an integer-arithmetic model of a+b+cin / a-b-cin.
module tb_cla_adder_pipe;
   localparam int W  = 16;
   localparam int TW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, in_cin, in_op;
   logic [W-1:0]  in_a, in_b;
   logic [TW-1:0] in_tag;
   logic          out_valid, out_ready, out_cout, out_ovf, out_zero;
   logic [W-1:0]  out_sum;
   logic [TW-1:0] out_tag;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
      logic        zero;
      logic [3:0]  tag;
   } res_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        op;
      logic [3:0]  tag;
      res_t        exp;
   } vec_t;

   res_t exp_q[$];
   logic hold_pend = 1'b0;
   res_t hold_r;

   always #5 clk = ~clk;

   cla_adder_pipe #(.WIDTH(16), .GROUP(4), .TAG_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .in_op     (in_op),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf),
      .out_zero  (out_zero),
      .out_tag   (out_tag)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", name, got, exp);
      end
   endtask

   function automatic logic [31:0] rb(input res_t r);
      return {9'd0, r};
   endfunction

   function automatic res_t cur_res();
      res_t r;
      r.sum  = out_sum;
      r.cout = out_cout;
      r.ovf  = out_ovf;
      r.zero = out_zero;
      r.tag  = out_tag;
      return r;
   endfunction

   // Signed/unsigned integer view of the operation, independent of any carry structure
   function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                  input logic cin, input logic op, input logic [3:0] tag);
      res_t r;
      int   full;
      int   sres;
      if (op == 1'b0) begin
         full   = int'(a) + int'(b) + int'(cin);
         sres   = int'($signed(a)) + int'($signed(b)) + int'(cin);
         r.cout = (full > 65535);
      end else begin
         full   = int'(a) - int'(b) - int'(cin);
         sres   = int'($signed(a)) - int'($signed(b)) - int'(cin);
         r.cout = (full >= 0);
      end
      r.sum  = full[15:0];
      r.ovf  = (sres > 32767) || (sres < -32768);
      r.zero = (full[15:0] == 16'h0000);
      r.tag  = tag;
      return r;
   endfunction

   task automatic monitor();
      res_t cur;
      res_t e;
      cur = cur_res();
      if (rst) begin
         hold_pend = 1'b0;
      end else begin
         if (hold_pend) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", rb(cur), rb(hold_r));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_unexpected_out got=%h expected=none", rb(cur));
            end else begin
               e = exp_q.pop_front();
               chk("sb_result", rb(cur), rb(e));
            end
         end
         hold_pend = out_valid && !out_ready;
         hold_r    = cur;
         if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_cin, in_op, in_tag));
      end
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_payload(input logic [3:0] tag);
      logic [15:0] edges [4];
      edges[0] = 16'hFFFF; edges[1] = 16'h8000; edges[2] = 16'h7FFF; edges[3] = 16'h0000;
      in_a   = ($urandom_range(0, 7) == 0) ? edges[$urandom_range(0, 3)] : 16'($urandom);
      in_b   = ($urandom_range(0, 7) == 0) ? edges[$urandom_range(0, 3)] : 16'($urandom);
      in_cin = 1'($urandom_range(0, 1));
      in_op  = 1'($urandom_range(0, 1));
      in_tag = tag;
   endtask

   initial begin
      vec_t tbl[11];
      int   acc;
      int   cyc;
      int   n_acc;
      logic fire;
      logic [3:0] tag_next;

      tbl[0]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 4'd3,  '{16'h0100, 1'b0, 1'b0, 1'b0, 4'd3}};
      tbl[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 4'd1,  '{16'h0000, 1'b1, 1'b0, 1'b1, 4'd1}};
      tbl[2]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 4'd2,  '{16'h8000, 1'b0, 1'b1, 1'b0, 4'd2}};
      tbl[3]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 4'd4,  '{16'h7FFF, 1'b1, 1'b1, 1'b0, 4'd4}};
      tbl[4]  = '{16'h0003, 16'h0005, 1'b0, 1'b1, 4'd5,  '{16'hFFFE, 1'b0, 1'b0, 1'b0, 4'd5}};
      tbl[5]  = '{16'h0005, 16'h0003, 1'b1, 1'b1, 4'd6,  '{16'h0001, 1'b1, 1'b0, 1'b0, 4'd6}};
      tbl[6]  = '{16'h1234, 16'h0FFF, 1'b1, 1'b0, 4'd7,  '{16'h2234, 1'b0, 1'b0, 1'b0, 4'd7}};
      tbl[7]  = '{16'h0000, 16'h0000, 1'b1, 1'b1, 4'd8,  '{16'hFFFF, 1'b0, 1'b0, 1'b0, 4'd8}};
      tbl[8]  = '{16'h1234, 16'h1234, 1'b0, 1'b1, 4'd9,  '{16'h0000, 1'b1, 1'b0, 1'b1, 4'd9}};
      tbl[9]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 4'd10, '{16'h0000, 1'b1, 1'b1, 1'b1, 4'd10}};
      tbl[10] = '{16'h0FFF, 16'h0000, 1'b1, 1'b0, 4'd11, '{16'h1000, 1'b0, 1'b0, 1'b0, 4'd11}};

      rst = 1'b1; in_valid = 1'b0; in_a = 16'h0; in_b = 16'h0; in_cin = 1'b0;
      in_op = 1'b0; in_tag = 4'h0; out_ready = 1'b1;
      repeat (2) tick();
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_outputs", rb(cur_res()), 32'd0);
      rst = 1'b0;
      tick();

      // Directed vectors: one op at a time, exact two-cycle latency
      foreach (tbl[i]) begin
         in_a = tbl[i].a; in_b = tbl[i].b; in_cin = tbl[i].cin;
         in_op = tbl[i].op; in_tag = tbl[i].tag; in_valid = 1'b1;
         chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
         tick();
         in_valid = 1'b0;
         chk($sformatf("vec%0d_early_valid", i), 32'(out_valid), 32'd0);
         tick();
         chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("vec%0d_result", i), rb(cur_res()), rb(tbl[i].exp));
         tick();
      end

      // Backpressure: exactly two ops held, then FIFO release of tags 0..5
      out_ready = 1'b0;
      tag_next  = 4'd0;
      acc       = 0;
      rand_payload(tag_next);
      in_valid = 1'b1;
      for (int c = 0; c < 6; c++) begin
         fire = in_valid && in_ready;
         tick();
         if (fire) begin
            acc++;
            tag_next = tag_next + 4'd1;
            rand_payload(tag_next);
         end
      end
      chk("bp_accepted", 32'(acc), 32'd2);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_head_tag", 32'(out_tag), 32'd0);
      out_ready = 1'b1;
      cyc = 0;
      while (tag_next < 4'd6 && cyc < 40) begin
         fire = in_valid && in_ready;
         tick();
         cyc++;
         if (fire) begin
            tag_next = tag_next + 4'd1;
            rand_payload(tag_next);
         end
      end
      in_valid = 1'b0;
      chk("bp_all_sent", 32'(tag_next), 32'd6);
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 20) begin
         tick();
         cyc++;
      end
      chk("bp_drained", 32'(exp_q.size()), 32'd0);

      // Random stream with random downstream stalls
      n_acc = 0;
      cyc   = 0;
      while (n_acc < 100 && cyc < 3000) begin
         if (!in_valid && ($urandom_range(0, 9) < 8)) begin
            rand_payload(4'($urandom));
            in_valid = 1'b1;
         end
         out_ready = 1'($urandom_range(0, 1));
         fire = in_valid && in_ready;
         tick();
         cyc++;
         if (fire) begin
            n_acc++;
            in_valid = 1'b0;
         end
      end
      chk("rand_count", 32'(n_acc), 32'd100);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 20) begin
         tick();
         cyc++;
      end
      chk("rand_drained", 32'(exp_q.size()), 32'd0);

      // Reset with both stages full: nothing stale may surface afterwards
      out_ready = 1'b0;
      rand_payload(4'd12);
      in_valid = 1'b1;
      tick();
      rand_payload(4'd13);
      tick();
      in_valid = 1'b0;
      chk("rst_pre_full", {30'd0, out_valid, in_ready}, 32'd2);
      rst = 1'b1;
      tick();
      exp_q.delete();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_outputs", rb(cur_res()), 32'd0);
      rst = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("rst_no_stale", 32'(out_valid), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
